// File: rtl/ai_move_engine_if.sv
// ai_move_engine_if
// Move hand-off bundle between the computer-player engine and the board
// writer (input controller / board-register path).
//   move_valid : engine -> consumer, move_xoro/row/col hold a valid move
//   move_xoro  : engine -> consumer, symbol to write (AI symbol while valid)
//   move_row   : engine -> consumer, row 0..2
//   move_col   : engine -> consumer, column 0..2
//   move_ready : consumer -> engine, move accepted on the sampling edge
interface ai_move_engine_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_xoro;
  logic [1:0] move_row;
  logic [1:0] move_col;

  modport master (
    output move_valid,
    output move_xoro,
    output move_row,
    output move_col,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_xoro,
    input  move_row,
    input  move_col,
    output move_ready
  );
endinterface

// File: rtl/ai_move_engine.sv
// ai_move_engine
// Computer-player stage. On start (while idle and no winner yet) it snapshots
// the board and walks the cells one per cycle in priority order:
// win, block, center, corners (0,2,6,8), edges (1,3,5,7). The chosen move is
// offered on the move interface until the consumer accepts it.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   start    : move request, only honoured in IDLE
//   board    : 18-bit board, cell i = row*3+col at bits [2i+1:2i]
//   win      : current win state, non-zero blocks a new request
//   mv       : move hand-off (master side)
//   busy     : high in every state except IDLE
//   no_move  : one-cycle pulse when no empty cell exists
module ai_move_engine #(
  parameter logic [1:0] AI_SYMBOL = 2'b01
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [17:0]             board,
  input  logic [1:0]              win,
  ai_move_engine_if.master        mv,
  output logic                    busy,
  output logic                    no_move
);

  localparam logic [1:0] OPP = (AI_SYMBOL == 2'b01) ? 2'b10 : 2'b01;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SCAN_WIN    = 3'd1,
    SCAN_BLOCK  = 3'd2,
    CENTER      = 3'd3,
    SCAN_CORNER = 3'd4,
    SCAN_EDGE   = 3'd5,
    PRESENT     = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  idx_r;
  logic [3:0]  idx_next_s;
  logic [17:0] snap_r;
  logic        snap_load_s;
  logic        hit_s;
  logic [3:0]  hit_cell_s;
  logic        no_move_s;

  logic        valid_d_s;
  logic [1:0]  xoro_d_s;
  logic [1:0]  row_d_s;
  logic [1:0]  col_d_s;
  logic        busy_d_s;
  logic        no_move_d_s;

  logic        move_valid_r;
  logic [1:0]  move_xoro_r;
  logic [1:0]  move_row_r;
  logic [1:0]  move_col_r;
  logic        busy_r;
  logic        no_move_r;

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
    cell_at = b[{i, 1'b0} +: 2];
  endfunction

  function automatic logic pair_is(input logic [17:0] b, input logic [3:0] a,
                                   input logic [3:0] c, input logic [1:0] sym);
    pair_is = (cell_at(b, a) == sym) && (cell_at(b, c) == sym);
  endfunction

  // Cell k is a hit when it is empty and the other two cells of any line
  // through it already hold sym.
  function automatic logic line_hit(input logic [17:0] b, input logic [3:0] k,
                                    input logic [1:0] sym);
    logic h;
    case (k)
      4'd0:    h = pair_is(b, 4'd1, 4'd2, sym) | pair_is(b, 4'd3, 4'd6, sym) | pair_is(b, 4'd4, 4'd8, sym);
      4'd1:    h = pair_is(b, 4'd0, 4'd2, sym) | pair_is(b, 4'd4, 4'd7, sym);
      4'd2:    h = pair_is(b, 4'd0, 4'd1, sym) | pair_is(b, 4'd5, 4'd8, sym) | pair_is(b, 4'd4, 4'd6, sym);
      4'd3:    h = pair_is(b, 4'd4, 4'd5, sym) | pair_is(b, 4'd0, 4'd6, sym);
      4'd4:    h = pair_is(b, 4'd3, 4'd5, sym) | pair_is(b, 4'd1, 4'd7, sym) |
                   pair_is(b, 4'd0, 4'd8, sym) | pair_is(b, 4'd2, 4'd6, sym);
      4'd5:    h = pair_is(b, 4'd3, 4'd4, sym) | pair_is(b, 4'd2, 4'd8, sym);
      4'd6:    h = pair_is(b, 4'd7, 4'd8, sym) | pair_is(b, 4'd0, 4'd3, sym) | pair_is(b, 4'd2, 4'd4, sym);
      4'd7:    h = pair_is(b, 4'd6, 4'd8, sym) | pair_is(b, 4'd1, 4'd4, sym);
      4'd8:    h = pair_is(b, 4'd6, 4'd7, sym) | pair_is(b, 4'd2, 4'd5, sym) | pair_is(b, 4'd0, 4'd4, sym);
      default: h = 1'b0;
    endcase
    line_hit = h && (cell_at(b, k) == 2'b00);
  endfunction

  function automatic logic [3:0] corner_cell(input logic [1:0] j);
    case (j)
      2'd0:    corner_cell = 4'd0;
      2'd1:    corner_cell = 4'd2;
      2'd2:    corner_cell = 4'd6;
      2'd3:    corner_cell = 4'd8;
      default: corner_cell = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] edge_cell(input logic [1:0] j);
    case (j)
      2'd0:    edge_cell = 4'd1;
      2'd1:    edge_cell = 4'd3;
      2'd2:    edge_cell = 4'd5;
      2'd3:    edge_cell = 4'd7;
      default: edge_cell = 4'd1;
    endcase
  endfunction

  // Returns {row, col} for cell index k, avoiding a divider.
  function automatic logic [3:0] rc_of(input logic [3:0] k);
    case (k)
      4'd0:    rc_of = {2'd0, 2'd0};
      4'd1:    rc_of = {2'd0, 2'd1};
      4'd2:    rc_of = {2'd0, 2'd2};
      4'd3:    rc_of = {2'd1, 2'd0};
      4'd4:    rc_of = {2'd1, 2'd1};
      4'd5:    rc_of = {2'd1, 2'd2};
      4'd6:    rc_of = {2'd2, 2'd0};
      4'd7:    rc_of = {2'd2, 2'd1};
      4'd8:    rc_of = {2'd2, 2'd2};
      default: rc_of = {2'd0, 2'd0};
    endcase
  endfunction

  // State, scan index and board snapshot registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      snap_r  <= 18'd0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      if (snap_load_s) begin
        snap_r <= board;
      end else begin
        snap_r <= snap_r;
      end
    end
  end

  // Next-state logic: walks the snapshot one cell per cycle
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    snap_load_s  = 1'b0;
    hit_s        = 1'b0;
    hit_cell_s   = 4'd0;
    no_move_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && (win == 2'b00)) begin
          state_next_s = SCAN_WIN;
          idx_next_s   = 4'd0;
          snap_load_s  = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN_WIN: begin
        if (line_hit(snap_r, idx_r, AI_SYMBOL)) begin
          hit_s        = 1'b1;
          hit_cell_s   = idx_r;
          state_next_s = PRESENT;
          idx_next_s   = 4'd0;
        end else if (idx_r == 4'd8) begin
          state_next_s = SCAN_BLOCK;
          idx_next_s   = 4'd0;
        end else begin
          idx_next_s = idx_r + 4'd1;
        end
      end
      SCAN_BLOCK: begin
        if (line_hit(snap_r, idx_r, OPP)) begin
          hit_s        = 1'b1;
          hit_cell_s   = idx_r;
          state_next_s = PRESENT;
          idx_next_s   = 4'd0;
        end else if (idx_r == 4'd8) begin
          state_next_s = CENTER;
          idx_next_s   = 4'd0;
        end else begin
          idx_next_s = idx_r + 4'd1;
        end
      end
      CENTER: begin
        if (cell_at(snap_r, 4'd4) == 2'b00) begin
          hit_s        = 1'b1;
          hit_cell_s   = 4'd4;
          state_next_s = PRESENT;
        end else begin
          state_next_s = SCAN_CORNER;
        end
        idx_next_s = 4'd0;
      end
      SCAN_CORNER: begin
        if (cell_at(snap_r, corner_cell(idx_r[1:0])) == 2'b00) begin
          hit_s        = 1'b1;
          hit_cell_s   = corner_cell(idx_r[1:0]);
          state_next_s = PRESENT;
          idx_next_s   = 4'd0;
        end else if (idx_r == 4'd3) begin
          state_next_s = SCAN_EDGE;
          idx_next_s   = 4'd0;
        end else begin
          idx_next_s = idx_r + 4'd1;
        end
      end
      SCAN_EDGE: begin
        // Index 4 is a reporting cycle after the last edge cell was tried.
        if (idx_r == 4'd4) begin
          no_move_s    = 1'b1;
          state_next_s = IDLE;
          idx_next_s   = 4'd0;
        end else if (cell_at(snap_r, edge_cell(idx_r[1:0])) == 2'b00) begin
          hit_s        = 1'b1;
          hit_cell_s   = edge_cell(idx_r[1:0]);
          state_next_s = PRESENT;
          idx_next_s   = 4'd0;
        end else begin
          idx_next_s = idx_r + 4'd1;
        end
      end
      PRESENT: begin
        if (mv.move_ready) begin
          state_next_s = IDLE;
          idx_next_s   = 4'd0;
        end else begin
          state_next_s = PRESENT;
        end
      end
      default: begin
        state_next_s = IDLE;
        idx_next_s   = 4'd0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    valid_d_s   = 1'b0;
    xoro_d_s    = 2'b00;
    row_d_s     = 2'b00;
    col_d_s     = 2'b00;
    busy_d_s    = (state_next_s != IDLE);
    no_move_d_s = no_move_s;
    if (hit_s) begin
      valid_d_s          = 1'b1;
      xoro_d_s           = AI_SYMBOL;
      {row_d_s, col_d_s} = rc_of(hit_cell_s);
    end else if (state_next_s == PRESENT) begin
      // Hold the offered move until it is accepted.
      valid_d_s = 1'b1;
      xoro_d_s  = AI_SYMBOL;
      row_d_s   = move_row_r;
      col_d_s   = move_col_r;
    end else begin
      valid_d_s = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      move_valid_r <= 1'b0;
      move_xoro_r  <= 2'b00;
      move_row_r   <= 2'b00;
      move_col_r   <= 2'b00;
      busy_r       <= 1'b0;
      no_move_r    <= 1'b0;
    end else begin
      move_valid_r <= valid_d_s;
      move_xoro_r  <= xoro_d_s;
      move_row_r   <= row_d_s;
      move_col_r   <= col_d_s;
      busy_r       <= busy_d_s;
      no_move_r    <= no_move_d_s;
    end
  end

  assign mv.move_valid = move_valid_r;
  assign mv.move_xoro  = move_xoro_r;
  assign mv.move_row   = move_row_r;
  assign mv.move_col   = move_col_r;
  assign busy          = busy_r;
  assign no_move       = no_move_r;

endmodule

// File: tb/tb_ai_move_engine.sv
// Bench for ai_move_engine (AI plays X): table of boards with expected move
// and latency, scoreboard queue, plus hand-written handshake/gating/reset runs.
module tb_ai_move_engine;
  localparam logic [1:0] X = 2'b01;
  localparam logic [1:0] O = 2'b10;
  localparam logic [1:0] E = 2'b00;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] board;
  logic [1:0]  win;
  logic        busy;
  logic        no_move;

  ai_move_engine_if mif();

  ai_move_engine #(.AI_SYMBOL(2'b01)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .board   (board),
    .win     (win),
    .mv      (mif),
    .busy    (busy),
    .no_move (no_move)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] board;
    logic        is_move;
    logic [1:0]  row;
    logic [1:0]  col;
    int          edge_n;
  } vec_t;

  vec_t vecs[10];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [17:0] mkb(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                                      input logic [1:0] c3, input logic [1:0] c4, input logic [1:0] c5,
                                      input logic [1:0] c6, input logic [1:0] c7, input logic [1:0] c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits up to 40 cycles for move_valid or no_move; n = edge count, 0 if none.
  task automatic wait_output(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mif.move_valid || no_move) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   n;
    @(negedge clk);
    board = v.board; win = 2'b00; start = 1'b1; mif.move_ready = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);
    // Scramble inputs during the scan: the snapshot must be used.
    start = 1'b0; board = 18'h3FFFF; win = 2'b11;
    chk({v.name, "/busy_after_start"}, busy, 1);
    wait_output(n);
    e = sb_q.pop_front();
    if (n == 0) begin
      chk({e.name, "/timeout"}, n, e.edge_n);
    end else begin
      chk({e.name, "/valid"},   mif.move_valid, e.is_move);
      chk({e.name, "/no_move"}, no_move, !e.is_move);
      chk({e.name, "/latency"}, n, e.edge_n);
      if (e.is_move) begin
        chk({e.name, "/row"},  mif.move_row, e.row);
        chk({e.name, "/col"},  mif.move_col, e.col);
        chk({e.name, "/xoro"}, mif.move_xoro, X);
        chk({e.name, "/busy_present"}, busy, 1);
        @(negedge clk);
        chk({e.name, "/valid_after_accept"}, mif.move_valid, 0);
        chk({e.name, "/busy_after_accept"},  busy, 0);
        chk({e.name, "/outs_cleared"}, {mif.move_xoro, mif.move_row, mif.move_col}, 0);
      end else begin
        chk({e.name, "/busy_at_no_move"}, busy, 0);
        @(negedge clk);
        chk({e.name, "/no_move_pulse_end"}, no_move, 0);
        chk({e.name, "/valid_stays_low"}, mif.move_valid, 0);
      end
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "/valid"},   mif.move_valid, 0);
    chk({name, "/xoro"},    mif.move_xoro, 0);
    chk({name, "/row_col"}, {mif.move_row, mif.move_col}, 0);
    chk({name, "/busy"},    busy, 0);
    chk({name, "/no_move"}, no_move, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{"win_row0",       mkb(X,X,E, E,E,E, E,E,E), 1'b1, 2'd0, 2'd2, 3};
    vecs[1] = '{"block_row1",     mkb(X,E,E, O,O,E, E,E,E), 1'b1, 2'd1, 2'd2, 15};
    vecs[2] = '{"center_empty",   mkb(E,E,E, E,E,E, E,E,E), 1'b1, 2'd1, 2'd1, 19};
    vecs[3] = '{"corner0",        mkb(E,E,E, E,O,E, E,E,E), 1'b1, 2'd0, 2'd0, 20};
    vecs[4] = '{"corner1",        mkb(X,E,E, E,O,E, E,E,E), 1'b1, 2'd0, 2'd2, 21};
    vecs[5] = '{"edge0",          mkb(X,E,O, E,O,E, O,E,X), 1'b1, 2'd0, 2'd1, 24};
    vecs[6] = '{"edge3",          mkb(X,O,X, X,X,O, O,E,X), 1'b1, 2'd2, 2'd1, 27};
    vecs[7] = '{"no_move_draw",   mkb(X,O,X, X,O,O, O,X,X), 1'b0, 2'd0, 2'd0, 28};
    vecs[8] = '{"win_lowest_k0",  mkb(E,E,X, E,X,E, E,E,X), 1'b1, 2'd0, 2'd0, 1};
    vecs[9] = '{"block_k8_diag",  mkb(O,X,E, E,O,E, E,E,E), 1'b1, 2'd2, 2'd2, 18};

    reset = 1'b1; start = 1'b0; board = 18'd0; win = 2'b00; mif.move_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_values");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // Handshake: hold move_ready low for 5 cycles while the board changes.
    @(negedge clk);
    board = vecs[0].board; win = 2'b00; start = 1'b1; mif.move_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_output(n);
    chk("hs/latency", n, 3);
    for (int i = 0; i < 5; i++) begin
      board = 18'($urandom);
      @(negedge clk);
      chk("hs/valid_held", mif.move_valid, 1);
      chk("hs/move_held", {mif.move_xoro, mif.move_row, mif.move_col}, {X, 2'd0, 2'd2});
      chk("hs/busy_held", busy, 1);
    end
    mif.move_ready = 1'b1;
    @(negedge clk);
    chk("hs/valid_low", mif.move_valid, 0);
    chk("hs/busy_low", busy, 0);
    @(negedge clk);
    chk("hs/ready_in_idle", mif.move_valid, 0);

    // Gating: start while a winner exists is ignored.
    @(negedge clk);
    board = 18'd0; win = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("gate/busy", busy, 0);
    @(negedge clk);
    chk("gate/busy2", busy, 0);
    chk("gate/valid", mif.move_valid, 0);

    // Reset during SCAN_BLOCK.
    @(negedge clk);
    board = 18'd0; win = 2'b00; start = 1'b1; mif.move_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("rst_blk/busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_blk");
    reset = 1'b0;
    run_vec(vecs[2]);

    // Reset during PRESENT with an unaccepted move.
    @(negedge clk);
    board = vecs[0].board; win = 2'b00; start = 1'b1; mif.move_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_output(n);
    chk("rst_pres/valid_before", mif.move_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_pres");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pres/stays_idle", busy, 0);
    run_vec(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
